// File: rtl/mvm_stream_sender_if.sv
// Valid/ready stream from the sender to the matrix-vector multiplier.
// master drives data/valid; slave returns ready.
interface mvm_stream_sender_if #(
    parameter int WIDTH = 8
) ();
    logic [WIDTH-1:0] m_data;
    logic             m_valid;
    logic             m_ready;

    modport master (
        output m_data,
        output m_valid,
        input  m_ready
    );

    modport slave (
        input  m_data,
        input  m_valid,
        output m_ready
    );
endinterface

// File: rtl/mvm_stream_sender.sv
// Buffers matrix A and vector x, then streams them to the multiplier.
// Optional MVM_TX_VEC_ONLY_EN adds vec_only to resend just x.
module mvm_stream_sender #(
    parameter int WIDTH = 8,
    parameter int NROWS = 4,
    parameter int NCOLS = 4,
    parameter int DEPTH = NROWS * NCOLS + NCOLS,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             start,
`ifdef MVM_TX_VEC_ONLY_EN
    input  logic             vec_only,
`endif
    output logic             busy,
    output logic             done,
    mvm_stream_sender_if.master m
);

    typedef enum logic [1:0] {
        IDLE,
        SEND_MAT,
        SEND_VEC,
        DONE_S
    } state_e;

    localparam int            MATN      = NROWS * NCOLS;
    localparam logic [AW-1:0] MAT_LAST  = AW'(MATN - 1);
    localparam logic [AW-1:0] VEC_FIRST = AW'(MATN);
    localparam logic [AW-1:0] LAST      = AW'(DEPTH - 1);
    localparam logic [AW:0]   DEPTH_X   = (AW + 1)'(DEPTH);

    state_e           state_q, state_d;
    logic [AW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             wr_ok;
    logic             go_vec;

`ifdef MVM_TX_VEC_ONLY_EN
    assign go_vec = vec_only;
`else
    assign go_vec = 1'b0;
`endif

    // Frame is frozen once a transfer starts; out-of-range writes vanish
    assign wr_ok = wr_en && (state_q == IDLE)
                && ({1'b0, wr_addr} < DEPTH_X);

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign m.m_data = mem_q[idx_q];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        m.m_valid = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (go_vec) begin
                        state_d = SEND_VEC;
                        idx_d   = VEC_FIRST;
                    end else begin
                        state_d = SEND_MAT;
                        idx_d   = '0;
                    end
                end
            end
            SEND_MAT: begin
                m.m_valid = 1'b1;
                busy      = 1'b1;
                if (m.m_ready) begin
                    idx_d = idx_q + 1'b1;
                    if (idx_q == MAT_LAST) begin
                        state_d = SEND_VEC;
                    end
                end
            end
            SEND_VEC: begin
                m.m_valid = 1'b1;
                busy      = 1'b1;
                if (m.m_ready) begin
                    if (idx_q == LAST) begin
                        state_d = DONE_S;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            DONE_S: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mvm_stream_sender.sv
// Directed bench for mvm_stream_sender with a beat scoreboard.
// Define MVM_TX_VEC_ONLY_EN to also exercise the vector-only start.
module tb_mvm_stream_sender;

    logic       clk;
    logic       reset;
    logic       wr_en;
    logic [4:0] wr_addr;
    logic [7:0] wr_data;
    logic       start;
    logic       busy;
    logic       done;
`ifdef MVM_TX_VEC_ONLY_EN
    logic       vec_only;
`endif

    mvm_stream_sender_if #(.WIDTH(8)) sif ();

    mvm_stream_sender dut (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .start   (start),
`ifdef MVM_TX_VEC_ONLY_EN
        .vec_only(vec_only),
`endif
        .busy    (busy),
        .done    (done),
        .m       (sif.master)
    );

    int         tests = 0;
    int         fails = 0;
    logic [7:0] model [20];
    logic [7:0] exp_q [$];
    logic       held_v = 1'b0;
    logic [7:0] held_d = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input logic [7:0] d);
        wr_en   = 1'b1;
        wr_addr = 5'(a);
        wr_data = d;
        tick();
        wr_en = 1'b0;
        if (a < 20) model[a] = d;
    endtask

    // Scoreboard side: accepted beats are compared at the falling edge
    always @(negedge clk) begin
        if (reset) begin
            held_v = 1'b0;
        end else begin
            if (held_v) begin
                chk("stall_valid", 32'(sif.m_valid), 32'd1);
                chk("stall_data", 32'(sif.m_data), 32'(held_d));
            end
            if (sif.m_valid && sif.m_ready) begin
                if (exp_q.size() == 0)
                    chk("unexpected_beat", exp_q.size(), 32'd1);
                else
                    chk("beat", 32'(sif.m_data), 32'(exp_q.pop_front()));
            end
            held_v = sif.m_valid && !sif.m_ready;
            held_d = sif.m_data;
        end
    end

    task automatic run_frame(input bit stall, input int wr_at,
                             input bit sw, input bit vo);
        int   n;
        int   nacc;
        bit   acc;
        bit   got;
        n    = vo ? 4 : 20;
        nacc = 0;
        got  = 1'b0;
        if (sw) model[0] = 8'h55;
        for (int i = 0; i < n; i++)
            exp_q.push_back(model[vo ? 16 + i : i]);
        start = 1'b1;
        if (sw) begin
            wr_en   = 1'b1;
            wr_addr = 5'd0;
            wr_data = 8'h55;
        end
`ifdef MVM_TX_VEC_ONLY_EN
        vec_only = vo;
`endif
        tick();
        start = 1'b0;
        wr_en = 1'b0;
`ifdef MVM_TX_VEC_ONLY_EN
        vec_only = 1'b0;
`endif
        chk("first_valid", 32'(sif.m_valid), 32'd1);
        for (int c = 0; c < 200 && !got; c++) begin
            sif.m_ready = stall ? ((c % 4 == 0) || (c % 4 == 3)) : 1'b1;
            wr_en   = (c == wr_at);
            wr_addr = 5'd0;
            wr_data = 8'hFF;
            acc = sif.m_valid && sif.m_ready;
            if (acc) nacc++;
            tick();
            wr_en = 1'b0;
            if (acc && nacc == n) begin
                chk("done_pulse", 32'(done), 32'd1);
                chk("done_valid", 32'(sif.m_valid), 32'd0);
                chk("done_busy", 32'(busy), 32'd1);
                got = 1'b1;
            end else if (done) begin
                chk("early_done", 32'(done), 32'd0);
            end
        end
        if (!got) chk("frame_timeout", 32'(got), 32'd1);
        sif.m_ready = 1'b1;
        tick();
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_done", 32'(done), 32'd0);
        chk("queue_empty", exp_q.size(), 32'd0);
    endtask

    initial begin
        int done_cnt;
        int vcnt;
        int d1;
        int v2;
        bit prev_v;
        bit sawd;

        reset       = 1'b1;
        wr_en       = 1'b0;
        wr_addr     = '0;
        wr_data     = '0;
        start       = 1'b0;
        sif.m_ready = 1'b0;
`ifdef MVM_TX_VEC_ONLY_EN
        vec_only    = 1'b0;
`endif
        for (int i = 0; i < 20; i++) model[i] = '0;
        tick();
        tick();
        chk("rst_valid", 32'(sif.m_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        reset = 1'b0;
        tick();

        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                wr(r * 4 + c, 8'(4 * r + c + 1));
        wr(16, 8'd10);
        wr(17, 8'd20);
        wr(18, 8'd30);
        wr(19, 8'd40);
        wr(20, 8'hEE);

        run_frame(1'b0, -1, 1'b0, 1'b0);
        run_frame(1'b1, -1, 1'b0, 1'b0);

        run_frame(1'b0, 3, 1'b0, 1'b0);
        run_frame(1'b0, -1, 1'b0, 1'b0);

        // Abort after seven accepted beats
        for (int i = 0; i < 20; i++) exp_q.push_back(model[i]);
        sif.m_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_valid", 32'(sif.m_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_left", exp_q.size(), 32'd13);
        sawd = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sawd |= done;
            tick();
        end
        chk("abort_no_done", 32'(sawd), 32'd0);
        exp_q.delete();
        run_frame(1'b0, -1, 1'b0, 1'b0);

        // Start held high: two frames, then start drops
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 20; i++) exp_q.push_back(model[i]);
        sif.m_ready = 1'b1;
        start    = 1'b1;
        done_cnt = 0;
        vcnt     = 0;
        d1       = -1;
        v2       = -1;
        prev_v   = 1'b0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            if (cyc == 40) start = 1'b0;
            tick();
            if (done) begin
                done_cnt++;
                if (d1 < 0) d1 = cyc + 1;
            end
            if (sif.m_valid) vcnt++;
            if (sif.m_valid && !prev_v && d1 >= 0 && v2 < 0) v2 = cyc + 1;
            prev_v = sif.m_valid;
        end
        start = 1'b0;
        chk("held_done_cnt", 32'(done_cnt), 32'd2);
        chk("held_valid_cnt", 32'(vcnt), 32'd40);
        chk("held_first_done", 32'(d1), 32'd21);
        chk("held_second_valid", 32'(v2), 32'd23);
        chk("held_queue", exp_q.size(), 32'd0);
        chk("held_idle", 32'(busy), 32'd0);

        run_frame(1'b0, -1, 1'b1, 1'b0);

`ifdef MVM_TX_VEC_ONLY_EN
        run_frame(1'b0, -1, 1'b0, 1'b1);
`endif

        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
